pe_mac_os: RTL

- Parametrised output-stationary processing element for the systolic matmul array. Generalises the INT8 PE in four ways: configurable operand and accumulator widths, signed or unsigned mode, optional saturation, and valid-qualified operand forwarding.
- Operands flow west→east and north→south with one-cycle registered forwarding.
- Each PE accumulates its own output tile element.
- Results are read out through a north→south drain shift chain. The bottom PE of each column feeds the output collector.

---
 rtl/pe_mac_os.sv | 121 ++++++++++++
 1 files changed

// File: rtl/pe_mac_os.sv
// pe_mac_os: output-stationary MAC processing element with valid-qualified operand forwarding and a drain shift chain
module pe_mac_os #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 32,
    parameter bit SIGNED = 1'b1,
    parameter bit SAT_EN = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] a_in,
    input  logic              a_valid_in,
    input  logic [DATA_W-1:0] b_in,
    input  logic              b_valid_in,
    input  logic              acc_clr,
    output logic [DATA_W-1:0] a_out,
    output logic              a_valid_out,
    output logic [DATA_W-1:0] b_out,
    output logic              b_valid_out,
    input  logic              drain_en,
    input  logic [ACC_W-1:0]  drain_in,
    input  logic              drain_valid_in,
    output logic [ACC_W-1:0]  drain_out,
    output logic              drain_valid_out,
    output logic              sat_flag
);
    localparam int PW = 2 * DATA_W;
    localparam int SW = ACC_W + 1;

    typedef enum logic [1:0] {ACC = 2'd0, DRAIN_SELF = 2'd1, DRAIN_FWD = 2'd2} state_t;

    state_t                  state, state_nxt;
    logic                    mac;
    logic signed [PW-1:0]    a_s, b_s, prod_s;
    logic        [PW-1:0]    prod_u, prod;
    logic        [SW-1:0]    prod_ext, acc_ext, sum;
    logic        [ACC_W-1:0] acc, sat_val, acc_sum;
    logic                    ovf, sat_hit;
    logic        [ACC_W-1:0] drain_nxt;
    logic                    drain_valid_nxt;

    if (ACC_W < 2 * DATA_W) begin : g_acc_w_chk
        $error("pe_mac_os: ACC_W must be at least 2*DATA_W");
    end

    assign mac = a_valid_in & b_valid_in & (state == ACC) & ~drain_en;

    // full-width product and one-bit-wider sum so overflow is a simple top-bit test
    always_comb begin
        a_s      = PW'($signed(a_in));
        b_s      = PW'($signed(b_in));
        prod_s   = a_s * b_s;
        prod_u   = PW'(a_in) * PW'(b_in);
        prod     = SIGNED ? prod_s : prod_u;
        prod_ext = SIGNED ? SW'($signed(prod)) : SW'(prod);
        acc_ext  = SIGNED ? SW'($signed(acc)) : SW'(acc);
        sum      = acc_ext + prod_ext;
        ovf      = SIGNED ? (sum[ACC_W] ^ sum[ACC_W-1]) : sum[ACC_W];
        sat_val  = SIGNED ? {sum[ACC_W], {(ACC_W-1){~sum[ACC_W]}}} : {ACC_W{1'b1}};
        sat_hit  = SAT_EN & ovf;
        acc_sum  = sat_hit ? sat_val : sum[ACC_W-1:0];
    end

    // drain state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ACC;
        else        state <= state_nxt;
    end

    // first drain cycle snapshots own acc, later cycles pass the north word through
    always_comb begin
        state_nxt = drain_en ? ((state == ACC) ? DRAIN_SELF : DRAIN_FWD) : ACC;
    end

    // drain chain next values; word holds when not draining
    always_comb begin
        drain_valid_nxt = drain_en & ((state == ACC) | drain_valid_in);
        drain_nxt       = !drain_en ? drain_out : (state == ACC) ? acc : drain_in;
    end

    // drain chain output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drain_out       <= '0;
            drain_valid_out <= 1'b0;
        end else begin
            drain_out       <= drain_nxt;
            drain_valid_out <= drain_valid_nxt;
        end
    end

    // operand forwarding: valids every cycle, data only on valid beats
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_out       <= '0;
            b_out       <= '0;
            a_valid_out <= 1'b0;
            b_valid_out <= 1'b0;
        end else begin
            a_valid_out <= a_valid_in;
            b_valid_out <= b_valid_in;
            if (a_valid_in) a_out <= a_in;
            if (b_valid_in) b_out <= b_in;
        end
    end

    // accumulator and sticky saturation flag, only touched while accumulating
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc      <= '0;
            sat_flag <= 1'b0;
        end else if (state == ACC && !drain_en) begin
            if (acc_clr) begin
                acc      <= mac ? prod_ext[ACC_W-1:0] : '0;
                sat_flag <= 1'b0;
            end else if (mac) begin
                acc      <= acc_sum;
                sat_flag <= sat_flag | sat_hit;
            end
        end
    end
endmodule
